regfile_bist: RTL and testbench
===============================

// Module: regfile_bist
// PURPOSE
//  Parametrised DEPTH x WIDTH register file: 1 synchronous write port, 2 synchronous read ports.
//  Built-in sweep engine: on start, writes a pattern to every entry, reads each back and compares,
//  then raises flag with pass/error count.
//  Successor to the fixed 32-bit start/flag/data register-file top; sits under the datapath as its GPR bank.
// PARAMETERS
//  WIDTH     32  data width in bits (>= clog2(DEPTH))
//  DEPTH     16  number of entries (power of 2, >= 2)
//  AW        4   address width, = clog2(DEPTH)
//  ZERO_REG  0   1: entry 0 hard-wired to zero; writes to it are dropped
//  ECW       8   error-counter width
// PORTS
//  clk      in   1      clock, all state on rising edge
//  rst      in   1      asynchronous, active-low reset
//  start    in   1      launch sweep; sampled in IDLE and DONE only
//  mode     in   1      sweep pattern: 0 = address, 1 = ~address; latched at start
//  we       in   1      external write enable (ignored while busy)
//  waddr    in   AW     external write address
//  wdata    in   WIDTH  external write data
//  raddr0   in   AW     read port 0 address
//  rdata0   out  WIDTH  read port 0 data, registered
//  raddr1   in   AW     read port 1 address
//  rdata1   out  WIDTH  read port 1 data, registered
//  busy     out  1      sweep in progress (WRITE or READ)
//  flag     out  1      sweep complete; held until next start or reset
//  pass     out  1      valid with flag: 1 = zero mismatches
//  err_cnt  out  ECW    mismatch count of last sweep, saturating at 2^ECW-1
//  data     out  WIDTH  last word read back by sweep engine
// BEHAVIOUR
//  Reset (rst=0, async): all entries, rdata0/1, data, err_cnt = 0; busy, flag, pass = 0; FSM = IDLE.
//  pat(a) = zero-extended a (mode 0) or its bitwise inverse over WIDTH bits (mode 1);
//   pat(0) = 0 when ZERO_REG=1.
//  Reads: rdataN <= mem[raddrN] each edge; 1-cycle latency.
//   Read-during-write to same address returns OLD data.
//   ZERO_REG=1 and raddr 0: always returns 0.
//  Ext write: mem[waddr] <= wdata at edge when we=1 and FSM in IDLE/DONE.
//  FSM states:
//   IDLE:  start=1 -> WRITE; ptr=0; err_cnt=0; flag=0; latch mode.
//   WRITE: mem[ptr] <= pat(ptr); ptr++.
//          At ptr=DEPTH-1 -> READ, ptr=0.
//   READ:  issue mem[ptr]; compare registered word to pat(ptr-1) one cycle later.
//          After last issue, one drain cycle -> DONE.
//   DONE:  flag=1; pass=(err_cnt==0). start=1 -> WRITE (flag clears same edge).
//  Latency: flag rises 2*DEPTH+2 edges after the edge sampling start. busy=1 for the preceding 2*DEPTH+1.
//  While busy: we ignored; start ignored; rdata0/1 still serve external reads.
//  data updates on each sweep compare.
//  err_cnt saturates, never wraps. pass=0 whenever flag=0.
//  Reset mid-sweep: immediate return to IDLE, memory cleared, no flag.
//  start held high continuously: one sweep per DONE visit, back-to-back.
// TESTING
//  1 Reset: rst=0 mid-run -> all outputs 0, rdata0 of any addr = 0 next cycle.
//  2 DEPTH=8, WIDTH=32, mode=0, start pulse -> flag at edge 18, pass=1, err_cnt=0,
//    data=32'h7; rdata0 @addr5 = 32'h5.
//  3 mode=1 sweep -> pass=1, addr3 reads 32'hFFFF_FFFC; ZERO_REG=1: addr0 reads 0, pass=1.
//  4 Force mem[2] corrupt mid-READ via hierarchical write -> err_cnt=1, pass=0.
//    ECW=2 with 8 forced errors -> err_cnt=3.
//  5 we=1 waddr=4 wdata=32'hDEAD_BEEF in IDLE -> rdata1 @4 = DEADBEEF.
//    Same write while busy -> dropped. Same-address read+write returns old value.
//  6 rst=0 at edge 6 of sweep -> IDLE, flag=0, busy=0; new start -> full sweep passes.

Source files
------------

// File: rtl/regfile_bist.sv
// regfile_bist: DEPTH x WIDTH register file (1 write, 2 registered read ports)
// with a built-in write/read-back sweep engine reporting pass and error count.
module regfile_bist #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = 4,
    parameter bit          ZERO_REG = 1'b0,
    parameter int unsigned ECW      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr0,
    output logic [WIDTH-1:0] rdata0,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    output logic             busy,
    output logic             flag,
    output logic             pass,
    output logic [ECW-1:0]   err_cnt,
    output logic [WIDTH-1:0] data
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state, state_nx;
    logic [AW-1:0]    ptr;
    logic             mode_q;
    logic             issue_done;
    logic             cmp_vld;
    logic [AW-1:0]    cmp_addr;
    logic [WIDTH-1:0] sweep_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             sw_we, ext_we, issue;
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] mem_wd;
    logic [WIDTH-1:0] rd0, rd1, rds;

    function automatic logic [WIDTH-1:0] pat(input logic [AW-1:0] a, input logic m);
        logic [WIDTH-1:0] p;
        p = WIDTH'(a);
        if (m) p = ~p;
        if (ZERO_REG && a == '0) p = '0;
        return p;
    endfunction

    always_comb begin
        state_nx = state;
        sw_we    = 1'b0;
        ext_we   = 1'b0;
        issue    = 1'b0;
        case (state)
            IDLE, DONE: begin
                ext_we = we;
                if (start) state_nx = WRITE;
            end
            WRITE: begin
                sw_we = 1'b1;
                if (ptr == LAST) state_nx = READ;
            end
            READ: begin
                issue = !issue_done;
                // one drain cycle after the last issue lets its compare land
                if (issue_done) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_we = sw_we | ext_we;
        mem_wa = sw_we ? ptr : waddr;
        mem_wd = sw_we ? pat(ptr, mode_q) : wdata;
        rd0    = (ZERO_REG && raddr0 == '0) ? '0 : mem[raddr0];
        rd1    = (ZERO_REG && raddr1 == '0) ? '0 : mem[raddr1];
        rds    = (ZERO_REG && ptr == '0)    ? '0 : mem[ptr];
    end

    assign busy = (state == WRITE) || (state == READ);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_we && !(ZERO_REG && mem_wa == '0)) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            rdata0 <= rd0;
            rdata1 <= rd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= '0;
            mode_q     <= 1'b0;
            issue_done <= 1'b0;
            cmp_vld    <= 1'b0;
            cmp_addr   <= '0;
            sweep_q    <= '0;
            flag       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            data       <= '0;
        end else begin
            cmp_vld <= issue;
            if (issue) begin
                sweep_q  <= rds;
                cmp_addr <= ptr;
            end
            case (state)
                IDLE, DONE: begin
                    // flag/pass register one cycle after DONE entry so the final compare is counted
                    if (state == DONE) begin
                        flag <= 1'b1;
                        pass <= (err_cnt == '0);
                    end
                    if (start) begin
                        ptr        <= '0;
                        err_cnt    <= '0;
                        flag       <= 1'b0;
                        pass       <= 1'b0;
                        mode_q     <= mode;
                        issue_done <= 1'b0;
                    end
                end
                WRITE: ptr <= (ptr == LAST) ? '0 : ptr + AW'(1);
                READ: begin
                    if (!issue_done) begin
                        if (ptr == LAST) issue_done <= 1'b1;
                        else             ptr        <= ptr + AW'(1);
                    end
                end
                default: ;
            endcase
            if (cmp_vld) begin
                data <= sweep_q;
                if (sweep_q != pat(cmp_addr, mode_q) && err_cnt != '1)
                    err_cnt <= err_cnt + ECW'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_bist.sv
// Directed scoreboard bench for regfile_bist: sweeps, zero register,
// error saturation, external writes and mid-sweep reset.
module tb_regfile_bist;

    localparam int unsigned W = 32;
    localparam int unsigned D = 8;
    localparam int unsigned A = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, mode, we;
    logic [A-1:0] waddr, raddr0, raddr1;
    logic [W-1:0] wdata;

    logic [W-1:0] rdata0, rdata1, data;
    logic         busy, flag, pass;
    logic [7:0]   err_cnt;
    logic [W-1:0] z_rdata0, z_rdata1, z_data;
    logic         z_busy, z_flag, z_pass;
    logic [7:0]   z_err_cnt;
    logic [W-1:0] e_rdata0, e_rdata1, e_data;
    logic         e_busy, e_flag, e_pass;
    logic [1:0]   e_err_cnt;

    always #5 clk = ~clk;

    regfile_bist #(.WIDTH(W), .DEPTH(D), .AW(A), .ZERO_REG(1'b0), .ECW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr0(raddr0), .rdata0(rdata0), .raddr1(raddr1), .rdata1(rdata1),
        .busy(busy), .flag(flag), .pass(pass), .err_cnt(err_cnt), .data(data));

    regfile_bist #(.WIDTH(W), .DEPTH(D), .AW(A), .ZERO_REG(1'b1), .ECW(8)) dut_z (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr0(raddr0), .rdata0(z_rdata0), .raddr1(raddr1), .rdata1(z_rdata1),
        .busy(z_busy), .flag(z_flag), .pass(z_pass), .err_cnt(z_err_cnt), .data(z_data));

    regfile_bist #(.WIDTH(W), .DEPTH(D), .AW(A), .ZERO_REG(1'b0), .ECW(2)) dut_e (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr0(raddr0), .rdata0(e_rdata0), .raddr1(raddr1), .rdata1(e_rdata1),
        .busy(e_busy), .flag(e_flag), .pass(e_pass), .err_cnt(e_err_cnt), .data(e_data));

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic push(input string t, input logic [31:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%h", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // edge count relative to the edge that sampled start
    task automatic wait_flag(input int already, output int n);
        n = already;
        while (flag !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic launch(input logic m);
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; mode = 1'b0; we = 1'b0;
        waddr = '0; wdata = '0; raddr0 = 3'd5; raddr1 = '0;
        tick(); tick();
        push("rst_busy", 0);    pop_check({31'b0, busy});
        push("rst_flag", 0);    pop_check({31'b0, flag});
        push("rst_pass", 0);    pop_check({31'b0, pass});
        push("rst_errcnt", 0);  pop_check({24'b0, err_cnt});
        push("rst_data", 0);    pop_check(data);
        push("rst_rdata0", 0);  pop_check(rdata0);
        rst = 1'b1;
        tick();

        // mode 0 sweep
        launch(1'b0);
        push("busy_after_start", 1); pop_check({31'b0, busy});
        wait_flag(0, n);
        push("m0_flag_edge", 18);    pop_check(32'(n));
        push("m0_pass", 1);          pop_check({31'b0, pass});
        push("m0_errcnt", 0);        pop_check({24'b0, err_cnt});
        push("m0_data", 32'h7);      pop_check(data);
        push("m0_busy_done", 0);     pop_check({31'b0, busy});
        push("m0_z_pass", 1);        pop_check({31'b0, z_pass});
        raddr0 = 3'd5;
        push("m0_rd0_a5", 32'h5);
        tick();
        pop_check(rdata0);

        // mode 1 sweep, zero register instance
        launch(1'b1);
        wait_flag(0, n);
        push("m1_flag_edge", 18);    pop_check(32'(n));
        push("m1_pass", 1);          pop_check({31'b0, pass});
        push("m1_z_pass", 1);        pop_check({31'b0, z_pass});
        push("m1_data", 32'hFFFF_FFF8); pop_check(data);
        raddr0 = 3'd3;
        push("m1_rd0_a3", 32'hFFFF_FFFC);
        tick();
        pop_check(rdata0);
        raddr0 = 3'd0;
        push("m1_rd0_a0", 32'hFFFF_FFFF);
        push("m1_z_rd0_a0", 32'h0);
        tick();
        pop_check(rdata0);
        pop_check(z_rdata0);

        // corruption after write phase, before any read issue
        launch(1'b0);
        for (int i = 1; i <= 8; i++) tick();
        dut.mem[2] = 32'h0000_0BAD;
        for (int i = 0; i < 8; i++) dut_e.mem[i] = 32'hFFFF_0000;
        wait_flag(8, n);
        push("cor_flag_edge", 18);   pop_check(32'(n));
        push("cor_errcnt", 1);       pop_check({24'b0, err_cnt});
        push("cor_pass", 0);         pop_check({31'b0, pass});
        push("sat_errcnt", 3);       pop_check({30'b0, e_err_cnt});
        push("sat_pass", 0);         pop_check({31'b0, e_pass});
        push("cor_z_pass", 1);       pop_check({31'b0, z_pass});

        // reset at edge 6 of a sweep
        launch(1'b0);
        for (int i = 1; i <= 6; i++) tick();
        rst = 1'b0;
        #1;
        push("mr_busy", 0);          pop_check({31'b0, busy});
        push("mr_flag", 0);          pop_check({31'b0, flag});
        push("mr_errcnt", 0);        pop_check({24'b0, err_cnt});
        push("mr_data", 0);          pop_check(data);
        raddr0 = 3'd5;
        push("mr_rd0_a5", 0);
        tick();
        pop_check(rdata0);
        rst = 1'b1;
        tick();
        push("mr_rd0_a5_cleared", 0); pop_check(rdata0);

        // idle external write with same-address read
        we = 1'b1; waddr = 3'd4; wdata = 32'hDEAD_BEEF; raddr1 = 3'd4;
        push("rdw_old", 0);
        tick();
        pop_check(rdata1);
        we = 1'b0;
        push("ext_wr_rd1", 32'hDEAD_BEEF);
        tick();
        pop_check(rdata1);

        // write while busy is dropped; external reads keep working
        launch(1'b0);
        for (int i = 1; i <= 9; i++) tick();
        we = 1'b1; waddr = 3'd4; wdata = 32'hDEAD_BEEF; raddr0 = 3'd1;
        push("busy_rd0_a1", 32'h1);
        tick();
        we = 1'b0;
        pop_check(rdata0);
        wait_flag(10, n);
        push("post_rst_flag_edge", 18); pop_check(32'(n));
        push("post_rst_pass", 1);       pop_check({31'b0, pass});
        raddr1 = 3'd4;
        push("busy_wr_dropped", 32'h4);
        tick();
        pop_check(rdata1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
